byte_assembler: RTL
===================

BYTE_ASSEMBLER -- requirements
Module: byte_assembler

Interface
REQ-001 Parameter MSB_FIRST, default 1, meaning 1 = first received bit lands in bit 7, 0 = first received bit lands in bit 0.
REQ-002 Parameter PARITY_EN, default 1, meaning 1 = a parity bit follows the 8 data bits, 0 = no parity bit.
REQ-003 Parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-low reset; sampled only on rising clk.
REQ-007 Port frame_start, input, 1, one-cycle pulse that starts or restarts a frame.
REQ-008 Port bit_valid, input, 1, bit_in is a valid serial bit this cycle.
REQ-009 Port bit_in, input, 1, serial data bit.
REQ-010 Port byte_out, output, 8, last assembled byte; registered; feeds the downstream 8-bit register data input.
REQ-011 Port byte_valid, output, 1, one-cycle pulse when byte_out is updated.
REQ-012 Port parity_err, output, 1, parity result of the byte currently on byte_out.
REQ-013 Port busy, output, 1, high when state is not IDLE.

Function
REQ-014 The block SHALL implement three states: IDLE, SHIFT, PARITY.
REQ-015 In IDLE: frame_start=1 -> SHIFT with bit count 0 and shift register cleared; bit_valid SHALL be ignored.
REQ-016 In SHIFT: each cycle with bit_valid=1 SHALL shift bit_in per MSB_FIRST and increment the bit count (0..7).
REQ-017 In SHIFT: cycles with bit_valid=0 SHALL hold all state; gaps of any length SHALL be allowed.
REQ-018 On acceptance of the 8th data bit with PARITY_EN=1, the block SHALL go to PARITY.
REQ-019 On acceptance of the 8th data bit with PARITY_EN=0, the block SHALL complete the frame and go to IDLE.
REQ-020 In PARITY: the first cycle with bit_valid=1 SHALL sample the parity bit, complete the frame, and go to IDLE.
REQ-021 On frame completion, at the same clock edge: byte_out SHALL load the assembled byte; byte_valid=1 for exactly the following cycle; parity_err SHALL load its result.
REQ-022 Latency: byte_valid SHALL be high in the cycle after the edge that sampled the final bit (data bit 8, or the parity bit).
REQ-023 parity_err SHALL be 1 iff the XOR of the 8 data bits and the parity bit is not PARITY_ODD; it SHALL be 0 when PARITY_EN=0.
REQ-024 A byte with a parity error SHALL still be delivered (byte_valid pulses, parity_err=1).
REQ-025 byte_out and parity_err SHALL hold between completions.
REQ-026 frame_start=1 in SHIFT or PARITY SHALL abort the partial frame: no byte_valid, count cleared, shift register cleared, state SHIFT.
REQ-027 frame_start SHALL take priority over a simultaneous bit_valid; that bit SHALL be discarded.
REQ-028 frame_start in the cycle byte_valid is high SHALL start a new frame normally without affecting that pulse.
REQ-029 busy SHALL be registered: high in SHIFT and PARITY, low in IDLE.

Reset
REQ-030 With reset=0 at a rising clk, the block SHALL set: state IDLE, count 0, shift register 0x00, byte_out 0x00, byte_valid 0, parity_err 0, busy 0.
REQ-031 Reset SHALL take priority over all inputs and SHALL discard any frame in progress without a byte_valid pulse.
REQ-032 Reset SHALL have no effect between clock edges.

Verification
REQ-033 Defaults; frame_start; bits 1,0,1,0,0,1,0,1; parity 0 -> byte_out=0xA5, byte_valid one cycle, parity_err=0, busy low afterwards.
REQ-034 Same stimulus with parity bit 1 -> byte_out=0xA5, parity_err=1, byte_valid one cycle.
REQ-035 MSB_FIRST=0, PARITY_EN=0; bits 0,0,0,1,0,0,1,0 with 3-cycle bit_valid gaps -> byte_out=0x48, byte_valid the cycle after the 8th bit.
REQ-036 Defaults; 5 bits, then frame_start with bit_valid=1 the same cycle, then full frame for 0x3C with parity 0 -> exactly one byte_valid, byte_out=0x3C.
REQ-037 Defaults; reset=0 for one cycle after 4 bits, then a full frame for 0x5A with parity 0 -> outputs all 0 during reset, then byte_out=0x5A.
REQ-038 No frame_start, 20 cycles of bit_valid=1 -> byte_valid never asserted, busy=0, byte_out unchanged.

Source files
------------

// File: rtl/byte_assembler.sv
// Serial-to-parallel byte assembler with optional parity bit.
// Ports: clk, reset (sync, active-low), frame_start, bit_valid, bit_in
//        -> byte_out[7:0], byte_valid, parity_err, busy.
module byte_assembler #(
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] byte_q, byte_d;
  logic       vld_q, vld_d;
  logic       perr_q, perr_d;
  logic       busy_q, busy_d;
  logic [7:0] shift_nx;

  // Next shift-register value if bit_in is accepted this cycle.
  always_comb begin
    if (MSB_FIRST) begin
      shift_nx = {sh_q[6:0], bit_in};
    end else begin
      shift_nx = {bit_in, sh_q[7:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    byte_d  = byte_q;
    vld_d   = 1'b0;
    perr_d  = perr_q;
    // frame_start wins over any bit this cycle and aborts a partial frame.
    if (frame_start) begin
      state_d = SHIFT;
      cnt_d   = 3'd0;
      sh_d    = 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
        end
        SHIFT: begin
          if (bit_valid) begin
            sh_d  = shift_nx;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (PARITY_EN) begin
                state_d = PARITY;
              end else begin
                state_d = IDLE;
                byte_d  = shift_nx;
                vld_d   = 1'b1;
                perr_d  = 1'b0;
              end
            end
          end
        end
        PARITY: begin
          if (bit_valid) begin
            state_d = IDLE;
            byte_d  = sh_q;
            vld_d   = 1'b1;
            perr_d  = ((^sh_q) ^ bit_in) != PARITY_ODD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= 8'h00;
      byte_q  <= 8'h00;
      vld_q   <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = vld_q;
  assign parity_err = perr_q;
  assign busy       = busy_q;

endmodule
